// File: rtl/i2c_register_sequencer.sv
// Sequences one I2C register write or read (1-4 bytes) through the bus arbiter and transceiver.
// Optional per-operation watchdog: define I2C_SEQUENCER_TIMEOUT_EN.
package i2c_sequencer_pkg;
    typedef struct packed {
        logic       tx_start;
        logic       tx_restart;
        logic       tx_stop;
        logic       tx_en;
        logic [7:0] tx_data;
        logic       rx_en;
        logic       rx_ack;
    } i2c_in_t;

    typedef struct packed {
        logic       tx_done;
        logic       tx_ack;
        logic       rx_rdy;
        logic [7:0] rx_out;
    } i2c_out_t;
endpackage

module i2c_register_sequencer
    import i2c_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_en,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_dev_addr,
    input  logic [7:0]  cmd_reg,
    input  logic [2:0]  cmd_len,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_status,
    output logic        arb_request,
    input  logic        arb_ack,
    output logic        arb_done,
    output i2c_in_t     txvr_cin,
    input  i2c_out_t    txvr_cout
);

    typedef enum logic [3:0] {
        S_IDLE, S_ARB, S_ADDR_W, S_PTR, S_WDATA, S_RESTART_R, S_RDATA, S_STOP, S_DONE
    } state_t;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_ADDR_NAK = 2'd1;
    localparam logic [1:0] ST_DATA_NAK = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    state_t      state_q, state_d;
    logic        first_q;
    logic        reenter, dec, shift, accept, tmo;
    logic [2:0]  cnt_q, len_eff;
    logic [1:0]  st_q, st_d;
    logic        write_q;
    logic [6:0]  dev_q;
    logic [7:0]  reg_q, wr_byte;
    logic [31:0] wdata_q, rdata_q;
    logic        unused_dev_lsb;

    assign unused_dev_lsb = cmd_dev_addr[0];
    assign accept         = (state_q == S_IDLE) && cmd_en;

    always_comb begin
        len_eff = (cmd_len > 3'd4) ? 3'd4 : cmd_len;
        if (!cmd_write && len_eff == 3'd0) len_eff = 3'd1;
    end

    // Write bytes go out MSB first, so the remaining count selects the byte lane.
    always_comb begin
        case (cnt_q)
            3'd1:    wr_byte = wdata_q[7:0];
            3'd2:    wr_byte = wdata_q[15:8];
            3'd3:    wr_byte = wdata_q[23:16];
            default: wr_byte = wdata_q[31:24];
        endcase
    end

`ifdef I2C_SEQUENCER_TIMEOUT_EN
    logic [31:0] tmo_cnt_q;

    // Counts cycles since the last strobe; the strobe cycle itself never times out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        tmo_cnt_q <= '0;
        else if (first_q)  tmo_cnt_q <= 32'd1;
        else if (!tmo)     tmo_cnt_q <= tmo_cnt_q + 32'd1;
    end

    assign tmo = !first_q && (tmo_cnt_q >= TIMEOUT_CYCLES);
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
    assign tmo            = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        reenter     = 1'b0;
        dec         = 1'b0;
        shift       = 1'b0;
        cmd_ready   = 1'b0;
        arb_request = 1'b0;
        arb_done    = 1'b0;
        rsp_valid   = 1'b0;
        txvr_cin    = '0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_en) state_d = S_ARB;
            end
            S_ARB: begin
                arb_request = first_q;
                if (arb_ack) state_d = S_ADDR_W;
            end
            S_ADDR_W: begin
                if (first_q) begin
                    txvr_cin.tx_start = 1'b1;
                    txvr_cin.tx_en    = 1'b1;
                    txvr_cin.tx_data  = {dev_q, 1'b0};
                end
                if (txvr_cout.tx_done) begin
                    if (!txvr_cout.tx_ack) begin
                        state_d = S_STOP;
                        st_d    = ST_ADDR_NAK;
                    end else begin
                        state_d = S_PTR;
                    end
                end else if (tmo) begin
                    state_d = S_STOP;
                    st_d    = ST_TIMEOUT;
                end
            end
            S_PTR: begin
                if (first_q) begin
                    txvr_cin.tx_en   = 1'b1;
                    txvr_cin.tx_data = reg_q;
                end
                if (txvr_cout.tx_done) begin
                    if (!txvr_cout.tx_ack) begin
                        state_d = S_STOP;
                        st_d    = ST_DATA_NAK;
                    end else if (!write_q) begin
                        state_d = S_RESTART_R;
                    end else if (cnt_q == 3'd0) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_WDATA;
                    end
                end else if (tmo) begin
                    state_d = S_STOP;
                    st_d    = ST_TIMEOUT;
                end
            end
            S_WDATA: begin
                if (first_q) begin
                    txvr_cin.tx_en   = 1'b1;
                    txvr_cin.tx_data = wr_byte;
                end
                if (txvr_cout.tx_done) begin
                    if (!txvr_cout.tx_ack) begin
                        state_d = S_STOP;
                        st_d    = ST_DATA_NAK;
                    end else if (cnt_q == 3'd1) begin
                        state_d = S_STOP;
                    end else begin
                        dec     = 1'b1;
                        reenter = 1'b1;
                    end
                end else if (tmo) begin
                    state_d = S_STOP;
                    st_d    = ST_TIMEOUT;
                end
            end
            S_RESTART_R: begin
                if (first_q) begin
                    txvr_cin.tx_restart = 1'b1;
                    txvr_cin.tx_en      = 1'b1;
                    txvr_cin.tx_data    = {dev_q, 1'b1};
                end
                if (txvr_cout.tx_done) begin
                    if (!txvr_cout.tx_ack) begin
                        state_d = S_STOP;
                        st_d    = ST_ADDR_NAK;
                    end else begin
                        state_d = S_RDATA;
                    end
                end else if (tmo) begin
                    state_d = S_STOP;
                    st_d    = ST_TIMEOUT;
                end
            end
            S_RDATA: begin
                if (first_q) begin
                    txvr_cin.rx_en  = 1'b1;
                    txvr_cin.rx_ack = (cnt_q != 3'd1);
                end
                if (txvr_cout.rx_rdy) begin
                    shift = 1'b1;
                    if (cnt_q == 3'd1) begin
                        state_d = S_STOP;
                    end else begin
                        dec     = 1'b1;
                        reenter = 1'b1;
                    end
                end else if (tmo) begin
                    state_d = S_STOP;
                    st_d    = ST_TIMEOUT;
                end
            end
            S_STOP: begin
                txvr_cin.tx_stop = first_q;
                if (txvr_cout.tx_done) begin
                    state_d = S_DONE;
                end else if (tmo) begin
                    state_d = S_DONE;
                    st_d    = ST_TIMEOUT;
                end
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                arb_done  = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            first_q    <= 1'b0;
            cnt_q      <= '0;
            st_q       <= ST_OK;
            rsp_rdata  <= '0;
            rsp_status <= ST_OK;
        end else begin
            state_q <= state_d;
            first_q <= (state_d != state_q) || reenter;
            if (accept) begin
                cnt_q <= len_eff;
                st_q  <= ST_OK;
            end else begin
                if (dec) cnt_q <= cnt_q - 3'd1;
                st_q <= st_d;
            end
            if (state_d == S_DONE) begin
                rsp_rdata  <= rdata_q;
                rsp_status <= st_d;
            end
        end
    end

    // Command payload is only meaningful after an accept, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            write_q <= cmd_write;
            dev_q   <= cmd_dev_addr[7:1];
            reg_q   <= cmd_reg;
            wdata_q <= cmd_wdata;
            rdata_q <= '0;
        end else if (shift) begin
            rdata_q <= {rdata_q[23:0], txvr_cout.rx_out};
        end
    end

endmodule

// File: doc/i2c_register_sequencer.md
# i2c_register_sequencer

- Sequences one complete I2C register transaction at a time: write or read of 1–4 bytes to an 8-bit register pointer on a 7-bit device.
- Drives the I2C transceiver through the `i2c_in_t` / `i2c_out_t` structs.
- Sits on one driver port of the I2C arbiter and uses its request/ack/done handshake to obtain the bus.
- Replaces hand-coded per-peripheral byte sequencing in sensor, PMIC and EEPROM drivers.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 100000: max cycles to wait on any single transceiver operation.

Ports:
- `clk`  in  1  sole clock; everything is sampled on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `cmd_en`  in  1  command strobe; accepted only when `cmd_ready`=1.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_dev_addr`  in  8  8-bit device address; bit 0 is ignored and replaced by the R/W bit.
- `cmd_reg`  in  8  register pointer.
- `cmd_len`  in  3  byte count.
- `cmd_wdata`  in  32  write data, right-justified.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  32  read data, right-justified; held until the next `rsp_valid`.
- `rsp_status`  out  2  0 OK, 1 address NAK, 2 data/pointer NAK, 3 timeout.
- `arb_request`  out  1  to arbiter `driver_request`.
- `arb_ack`  in  1  from arbiter `driver_ack`.
- `arb_done`  out  1  to arbiter `driver_done`.
- `txvr_cin`  out  `i2c_in_t`  transceiver command.
- `txvr_cout`  in  `i2c_out_t`  transceiver status.

## Operation
- Command capture happens in the accept cycle: `cmd_*` are registered; later changes to the inputs are ignored.
- Length rules:
  - `cmd_len` >4 is clamped to 4.
  - A write with len 0 sends the pointer only.
  - A read with len 0 is treated as len 1.
- State machine:
  - IDLE → ARB: `arb_request` pulses one cycle.
  - ARB → ADDR_W on `arb_ack`.
  - ADDR_W: pulse `tx_start`+`tx_en`, `tx_data`={dev[7:1],0}.
  - PTR: pulse `tx_en`, `tx_data`=reg.
  - Write path: WDATA once per byte, MSB first: byte k = `wdata[8*(len-1-k)+:8]`.
  - Read path: RESTART_R pulses `tx_restart`+`tx_en`, `tx_data`={dev[7:1],1}. Then RDATA once per byte: pulse `rx_en`, with `rx_ack`=1 for every byte except the last, which gets `rx_ack`=0.
  - STOP: pulse `tx_stop`.
  - DONE: `rsp_valid`, `arb_done` and `rsp_status` all asserted in the same cycle, then IDLE.
- Each transmit state waits for `txvr_cout.tx_done`, then samples `tx_ack`.
  - `tx_ack`=0 in ADDR_W or RESTART_R → STOP with status 1.
  - `tx_ack`=0 in PTR or WDATA → STOP with status 2.
- RDATA waits for `rx_rdy`, then `rdata` ← {`rdata`[23:0], `rx_out`}. `rdata` is cleared at accept, so bytes above len stay 0.
- `txvr_cin` fields are 0 in every cycle except the single strobe cycle of each state.
- A byte counter (3 bits) counts down from len; the last byte is detected when counter == 1.

## Timing
- Reset values: `cmd_ready`=1; all other outputs 0 (`rsp_rdata`=0, `rsp_status`=0, `txvr_cin`='0).
- Acceptance to `arb_request` is 1 cycle; `cmd_ready` drops in the cycle after acceptance.
- Each transceiver strobe is issued 1 cycle after state entry. The next state is entered in the cycle after `tx_done`/`rx_rdy`.
- `cmd_en` asserted while `cmd_ready`=0 is ignored; no queueing.
- Once `arb_done` is issued, `cmd_ready`=1 again in the next cycle. A back-to-back command may be accepted then.
- `tx_done` and `rx_rdy` arriving in the strobe cycle itself are valid completions.
- Reset mid-transaction: the FSM returns to IDLE immediately and no STOP is issued. Bus recovery is software's job.

## Configuration
- `I2C_SEQUENCER_TIMEOUT_EN` defined:
  - A counter restarts at each strobe. When it reaches `TIMEOUT_CYCLES` without completion, the FSM goes to STOP with status 3.
  - A timeout in STOP itself goes directly to DONE with status 3.
- Undefined: no counter; the FSM waits indefinitely and status 3 is never produced.

## Test plan
- Write dev 0x90, reg 0x12, len 2, wdata 0xABCD, all ACK → bytes 0x90, 0x12, 0xAB, 0xCD then STOP; `rsp_status`=0; one `arb_done` pulse.
- Read dev 0x90, reg 0x05, len 3, device returns 0x11, 0x22, 0x33 → restart byte 0x91; `rx_ack` 1, 1, 0; `rsp_rdata`=0x00112233; status 0.
- Address NAK on a write → STOP issued; status 1; no PTR byte sent. NAK on the 2nd data byte → status 2; remaining bytes not sent.
- `arb_ack` delayed 50 cycles, and `cmd_en` pulsed again meanwhile → no transceiver strobe before ack; the second command is ignored.
- With `I2C_SEQUENCER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=20, `tx_done` never asserted → STOP then DONE; status 3; `cmd_ready` returns.
- `rst_n` low during RDATA → all outputs at reset values in the same cycle; a new command is accepted cleanly after release.
